// File: rtl/rect_cmd_scheduler_pkg.sv
// Shared shape-command types for the GPU shape schedulers: state encoding,
// the rectangle command record and corner normalization.
package gpu_shape_pkg;

  localparam int COORD_W = 8;
  localparam int COLOR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               fill;
    logic [COLOR_W-1:0] color;
  } rect_cmd_t;

  // Orders the corners so (x0,y0) is top-left; equal coordinates pass through.
  function automatic rect_cmd_t normalize(input rect_cmd_t c);
    rect_cmd_t n;
    n = c;
    if (c.x0 > c.x1) begin
      n.x0 = c.x1;
      n.x1 = c.x0;
    end
    if (c.y0 > c.y1) begin
      n.y0 = c.y1;
      n.y1 = c.y0;
    end
    return n;
  endfunction

endpackage

// File: rtl/rect_cmd_scheduler_if.sv
// Requester + engine bundle of the rectangle command scheduler.
// SCHED_WATCHDOG_EN adds the eng_abort / err_timeout signals.
interface rect_cmd_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    import gpu_shape_pkg::*;

    logic [N_REQ-1:0]         req;
    logic [COORD_W*N_REQ-1:0] req_x0;
    logic [COORD_W*N_REQ-1:0] req_y0;
    logic [COORD_W*N_REQ-1:0] req_x1;
    logic [COORD_W*N_REQ-1:0] req_y1;
    logic [N_REQ-1:0]         req_fill;
    logic [COLOR_W*N_REQ-1:0] req_color;

    logic [N_REQ-1:0]         ack;
    logic [N_REQ-1:0]         cmd_done;
    logic                     busy;
    logic [ID_W-1:0]          owner;
    logic [1:0]               dbg_state;

    logic                     eng_start;
    logic [COORD_W-1:0]       eng_x0;
    logic [COORD_W-1:0]       eng_y0;
    logic [COORD_W-1:0]       eng_x1;
    logic [COORD_W-1:0]       eng_y1;
    logic                     eng_fill;
    logic [COLOR_W-1:0]       eng_color;
    logic                     eng_done;
`ifdef SCHED_WATCHDOG_EN
    logic                     eng_abort;
    logic                     err_timeout;
`endif

    // Handshake: a requester holds req and its fields stable until it sees its
    // ack bit (one-cycle pulse); req still high after ack is a fresh request,
    // req dropped before ack withdraws it. eng_start/eng_done are single pulses.

    // master: requesters plus the rasterizer engine (the environment)
    modport master (
        output req, req_x0, req_y0, req_x1, req_y1, req_fill, req_color, eng_done,
        input  ack, cmd_done, busy, owner, dbg_state,
        input  eng_start, eng_x0, eng_y0, eng_x1, eng_y1, eng_fill, eng_color
`ifdef SCHED_WATCHDOG_EN
        , input eng_abort, err_timeout
`endif
    );

    // slave: the scheduler itself
    modport slave (
        input  req, req_x0, req_y0, req_x1, req_y1, req_fill, req_color, eng_done,
        output ack, cmd_done, busy, owner, dbg_state,
        output eng_start, eng_x0, eng_y0, eng_x1, eng_y1, eng_fill, eng_color
`ifdef SCHED_WATCHDOG_EN
        , output eng_abort, err_timeout
`endif
    );

endinterface

// File: rtl/rect_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit searching upward from
// ptr+1 with wrap. Shared by the shape schedulers.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    always_comb begin
        logic [ID_W-1:0] idx;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/rect_cmd_scheduler.sv
// Shares one rectangle rasterizer among N_REQ requesters (round-robin).
// Optional SCHED_WATCHDOG_EN aborts a draw that exceeds WDT_CYCLES.
module rect_cmd_scheduler
    import gpu_shape_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int WDT_CYCLES = 70000
) (
    input logic                  clk,
    input logic                  rst,
    rect_cmd_scheduler_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_ISSUE = 2'(ST_ISSUE);
    localparam logic [1:0] S_WAIT  = 2'(ST_WAIT);

    if (N_REQ < 2 || N_REQ > 8 || ID_W != $clog2(N_REQ) || WDT_CYCLES < 2) begin : g_bad_cfg
        $error("rect_cmd_scheduler: invalid N_REQ/ID_W/WDT_CYCLES");
    end

    logic [1:0]       state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [N_REQ-1:0] ack_q;
    logic [N_REQ-1:0] done_q;
    logic             busy_q;
    logic [ID_W-1:0]  owner_q;
    logic             start_q;
    rect_cmd_t        eng_q;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    rect_cmd_t        cmd_arr [N_REQ];
    rect_cmd_t        cmd_sel;

`ifdef SCHED_WATCHDOG_EN
    localparam int              WDT_W    = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdt_cnt;
    logic             abort_q;
    logic             err_q;
`endif

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cmd_arr[i].x0    = bus.req_x0[COORD_W*i +: COORD_W];
            cmd_arr[i].y0    = bus.req_y0[COORD_W*i +: COORD_W];
            cmd_arr[i].x1    = bus.req_x1[COORD_W*i +: COORD_W];
            cmd_arr[i].y1    = bus.req_y1[COORD_W*i +: COORD_W];
            cmd_arr[i].fill  = bus.req_fill[i];
            cmd_arr[i].color = bus.req_color[COLOR_W*i +: COLOR_W];
        end
    end

    assign cmd_sel = cmd_arr[grant_id];

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
        .req      (bus.req),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= ID_W'(N_REQ - 1);
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            start_q <= 1'b0;
            eng_q   <= '0;
`ifdef SCHED_WATCHDOG_EN
            wdt_cnt <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
            abort_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        ack_q   <= grant;
                        owner_q <= grant_id;
                        ptr_q   <= grant_id;
                        busy_q  <= 1'b1;
                        eng_q   <= normalize(cmd_sel);
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b1;
                    state_q <= S_WAIT;
`ifdef SCHED_WATCHDOG_EN
                    wdt_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    // eng_done takes priority over a coincident timeout
                    if (bus.eng_done) begin
                        done_q  <= N_REQ'(1) << owner_q;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
`ifdef SCHED_WATCHDOG_EN
                    else if (wdt_cnt == WDT_LAST) begin
                        abort_q <= 1'b1;
                        err_q   <= 1'b1;
                        done_q  <= N_REQ'(1) << owner_q;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wdt_cnt <= wdt_cnt + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.cmd_done  = done_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.dbg_state = state_q;
    assign bus.eng_start = start_q;
    assign bus.eng_x0    = eng_q.x0;
    assign bus.eng_y0    = eng_q.y0;
    assign bus.eng_x1    = eng_q.x1;
    assign bus.eng_y1    = eng_q.y1;
    assign bus.eng_fill  = eng_q.fill;
    assign bus.eng_color = eng_q.color;
`ifdef SCHED_WATCHDOG_EN
    assign bus.eng_abort   = abort_q;
    assign bus.err_timeout = err_q;
`endif

endmodule

// File: tb/tb_rect_cmd_scheduler.sv
// Directed bench for rect_cmd_scheduler with a latency-programmable engine
// model; the watchdog scenario runs when SCHED_WATCHDOG_EN is defined.
module tb_rect_cmd_scheduler;
    import gpu_shape_pkg::*;

    localparam int N_REQ      = 4;
    localparam int ID_W       = 2;
    localparam int WDT_CYCLES = 100;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    int eng_lat = 0;
    bit eng_en  = 1'b0;
    int eng_cnt = -1;

    rect_cmd_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    rect_cmd_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .WDT_CYCLES(WDT_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- engine model ----------------
    // eng_done pulses eng_lat cycles after eng_start is seen (0 = next edge).
    initial begin
        bus.eng_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.eng_done = 1'b0;
            if (rst) eng_cnt = -1;
            else if (bus.eng_start && eng_en) eng_cnt = eng_lat;
            else if (eng_cnt > 0) eng_cnt--;
            if (eng_cnt == 0) begin
                bus.eng_done = 1'b1;
                eng_cnt = -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cmd(input int i, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1,
                           input logic fill, input logic [23:0] color);
        bus.req_x0[8*i +: 8]     = x0;
        bus.req_y0[8*i +: 8]     = y0;
        bus.req_x1[8*i +: 8]     = x1;
        bus.req_y1[8*i +: 8]     = y1;
        bus.req_fill[i]          = fill;
        bus.req_color[24*i +: 24] = color;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        bus.req = '0; bus.req_x0 = '0; bus.req_y0 = '0; bus.req_x1 = '0;
        bus.req_y1 = '0; bus.req_fill = '0; bus.req_color = '0;
        repeat (2) tick;
        vectors++; if (bus.ack !== 4'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
        vectors++; if (bus.cmd_done !== 4'b0) begin miscompares++; $display("FAIL reset_cmd_done got %b want 0000", bus.cmd_done); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.eng_start !== 1'b0) begin miscompares++; $display("FAIL reset_eng_start got %b want 0", bus.eng_start); end
        vectors++; if (bus.owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner got %0d want 0", bus.owner); end
        vectors++; if (bus.dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", bus.dbg_state); end
        vectors++;
        if ({bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1, bus.eng_fill, bus.eng_color} !== 57'd0) begin
            miscompares++; $display("FAIL reset_eng_fields got nonzero want 0");
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single_cmd;
        int n;
        set_cmd(0, 8'd10, 8'd20, 8'd13, 8'd22, 1'b1, 24'hFF0000);
        eng_lat = 12; eng_en = 1'b1;
        bus.req = 4'b0001;
        tick;
        vectors++; if (bus.ack !== 4'b0001) begin miscompares++; $display("FAIL single_ack got %b want 0001", bus.ack); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b want 1", bus.busy); end
        vectors++; if (bus.dbg_state !== 2'd1) begin miscompares++; $display("FAIL single_state_issue got %0d want 1", bus.dbg_state); end
        vectors++; if (bus.eng_start !== 1'b0) begin miscompares++; $display("FAIL single_start_early got %b want 0", bus.eng_start); end
        vectors++;
        if ({bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1} !== {8'd10, 8'd20, 8'd13, 8'd22}) begin
            miscompares++; $display("FAIL single_corners got %0d,%0d,%0d,%0d want 10,20,13,22",
                                    bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1);
        end
        vectors++;
        if ({bus.eng_fill, bus.eng_color} !== {1'b1, 24'hFF0000}) begin
            miscompares++; $display("FAIL single_fill_color got %b/%h want 1/ff0000", bus.eng_fill, bus.eng_color);
        end
        bus.req = 4'b0000;
        tick;
        vectors++; if (bus.eng_start !== 1'b1) begin miscompares++; $display("FAIL single_start got %b want 1", bus.eng_start); end
        vectors++; if (bus.ack !== 4'b0) begin miscompares++; $display("FAIL single_ack_clear got %b want 0000", bus.ack); end
        tick;
        n = 1;
        vectors++; if (bus.eng_start !== 1'b0) begin miscompares++; $display("FAIL single_start_width got %b want 0", bus.eng_start); end
        while (bus.cmd_done === 4'b0 && n < 200) begin tick; n++; end
        vectors++; if (n !== 13) begin miscompares++; $display("FAIL single_done_latency got %0d want 13", n); end
        vectors++; if (bus.cmd_done !== 4'b0001) begin miscompares++; $display("FAIL single_cmd_done got %b want 0001", bus.cmd_done); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall got %b want 0", bus.busy); end
        tick;
        vectors++; if (bus.cmd_done !== 4'b0) begin miscompares++; $display("FAIL single_done_clear got %b want 0000", bus.cmd_done); end
        vectors++;
        if ({bus.eng_x0, bus.eng_x1} !== {8'd10, 8'd13}) begin
            miscompares++; $display("FAIL single_hold_idle got %0d,%0d want 10,13", bus.eng_x0, bus.eng_x1);
        end
    endtask

    task automatic test_swapped_corners;
        int n;
        set_cmd(1, 8'd50, 8'd40, 8'd5, 8'd3, 1'b0, 24'h00FF00);
        eng_lat = 0; eng_en = 1'b1;
        bus.req = 4'b0010;
        tick;
        vectors++; if (bus.ack !== 4'b0010) begin miscompares++; $display("FAIL swap_ack got %b want 0010", bus.ack); end
        vectors++; if (bus.owner !== 2'd1) begin miscompares++; $display("FAIL swap_owner got %0d want 1", bus.owner); end
        vectors++;
        if ({bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1} !== {8'd5, 8'd3, 8'd50, 8'd40}) begin
            miscompares++; $display("FAIL swap_corners got %0d,%0d,%0d,%0d want 5,3,50,40",
                                    bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1);
        end
        vectors++; if (bus.eng_fill !== 1'b0) begin miscompares++; $display("FAIL swap_fill got %b want 0", bus.eng_fill); end
        bus.req = 4'b0000;
        n = 0;
        while (bus.cmd_done === 4'b0 && n < 40) begin tick; n++; end
        vectors++; if (bus.cmd_done !== 4'b0010) begin miscompares++; $display("FAIL swap_cmd_done got %b want 0010", bus.cmd_done); end
        tick;
    endtask

    task automatic test_round_robin;
        int n;
        bit saw_done;
        logic [3:0] exp_ack;
        rst = 1'b1; tick; rst = 1'b0;
        for (int i = 0; i < 4; i++)
            set_cmd(i, 8'(i * 10), 8'(i), 8'(i * 10 + 5), 8'(i + 1), 1'b1, 24'(i));
        eng_lat = 3; eng_en = 1'b1;
        bus.req = 4'b1111;
        saw_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.ack === 4'b0 && n < 40) begin
                tick; n++;
                if (bus.cmd_done !== 4'b0) saw_done = 1'b1;
            end
            exp_ack = 4'(1 << (k % 4));
            vectors++; if (bus.ack !== exp_ack) begin miscompares++; $display("FAIL rr_ack%0d got %b want %b", k, bus.ack, exp_ack); end
            vectors++; if (saw_done !== 1'b1) begin miscompares++; $display("FAIL rr_order%0d got ack before cmd_done want cmd_done first", k); end
            vectors++;
            if (bus.eng_x0 !== 8'((k % 4) * 10)) begin
                miscompares++; $display("FAIL rr_fields%0d got x0=%0d want %0d", k, bus.eng_x0, (k % 4) * 10);
            end
            saw_done = 1'b0;
            if (k == 4) bus.req = 4'b0000;
            tick;
            vectors++; if (bus.ack !== 4'b0) begin miscompares++; $display("FAIL rr_single_ack%0d got %b want 0000", k, bus.ack); end
        end
        n = 0;
        while (bus.cmd_done === 4'b0 && n < 40) begin tick; n++; end
        vectors++; if (bus.cmd_done !== 4'b0001) begin miscompares++; $display("FAIL rr_last_done got %b want 0001", bus.cmd_done); end
        tick;
    endtask

    task automatic test_back_to_back;
        int n;
        set_cmd(2, 8'd100, 8'd200, 8'd90, 8'd210, 1'b0, 24'h123456);
        set_cmd(3, 8'd7, 8'd7, 8'd7, 8'd7, 1'b1, 24'hABCDEF);
        eng_lat = 0; eng_en = 1'b1;
        bus.req = 4'b1100;
        tick;
        vectors++; if (bus.ack !== 4'b0100) begin miscompares++; $display("FAIL b2b_ack2 got %b want 0100", bus.ack); end
        bus.req = 4'b1000;
        n = 0;
        while (bus.cmd_done === 4'b0 && n < 40) begin
            vectors++;
            if ({bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1, bus.eng_color} !==
                {8'd90, 8'd200, 8'd100, 8'd210, 24'h123456}) begin
                miscompares++; $display("FAIL b2b_stable cycle %0d got %0d,%0d,%0d,%0d want 90,200,100,210",
                                        n, bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1);
            end
            tick; n++;
        end
        vectors++; if (bus.cmd_done !== 4'b0100) begin miscompares++; $display("FAIL b2b_done2 got %b want 0100", bus.cmd_done); end
        vectors++; if (bus.ack !== 4'b0) begin miscompares++; $display("FAIL b2b_overlap got ack %b want 0000", bus.ack); end
        tick;
        vectors++; if (bus.ack !== 4'b1000) begin miscompares++; $display("FAIL b2b_ack3 got %b want 1000", bus.ack); end
        vectors++;
        if ({bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1, bus.eng_fill} !== {8'd7, 8'd7, 8'd7, 8'd7, 1'b1}) begin
            miscompares++; $display("FAIL b2b_point got %0d,%0d,%0d,%0d want 7,7,7,7",
                                    bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1);
        end
        bus.req = 4'b0000;
        n = 0;
        while (bus.cmd_done === 4'b0 && n < 40) begin tick; n++; end
        vectors++; if (bus.cmd_done !== 4'b1000) begin miscompares++; $display("FAIL b2b_done3 got %b want 1000", bus.cmd_done); end
        tick;
    endtask

    task automatic test_reset_mid;
        int n;
        eng_en = 1'b0;
        bus.req = 4'b0010;
        tick;
        vectors++; if (bus.ack !== 4'b0010) begin miscompares++; $display("FAIL rstmid_ack got %b want 0010", bus.ack); end
        bus.req = 4'b0000;
        tick;
        vectors++; if (bus.eng_start !== 1'b1) begin miscompares++; $display("FAIL rstmid_start got %b want 1", bus.eng_start); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        vectors++; if (bus.eng_start !== 1'b0) begin miscompares++; $display("FAIL rstmid_start_clr got %b want 0", bus.eng_start); end
        vectors++; if (bus.ack !== 4'b0) begin miscompares++; $display("FAIL rstmid_ack_clr got %b want 0000", bus.ack); end
        vectors++; if (bus.dbg_state !== 2'd0) begin miscompares++; $display("FAIL rstmid_state got %0d want 0", bus.dbg_state); end
        tick;
        rst = 1'b0;
        eng_en = 1'b1; eng_lat = 1;
        bus.req = 4'b1001;
        tick;
        vectors++; if (bus.ack !== 4'b0001) begin miscompares++; $display("FAIL rstmid_regrant got %b want 0001", bus.ack); end
        bus.req = 4'b0000;
        n = 0;
        while (bus.cmd_done === 4'b0 && n < 40) begin tick; n++; end
        vectors++; if (bus.cmd_done !== 4'b0001) begin miscompares++; $display("FAIL rstmid_done got %b want 0001", bus.cmd_done); end
        tick;
    endtask

`ifdef SCHED_WATCHDOG_EN
    task automatic test_watchdog;
        int n;
        eng_en = 1'b0;
        vectors++; if (bus.err_timeout !== 1'b0) begin miscompares++; $display("FAIL wdt_err_initial got %b want 0", bus.err_timeout); end
        bus.req = 4'b0100;
        tick;
        vectors++; if (bus.ack !== 4'b0100) begin miscompares++; $display("FAIL wdt_ack got %b want 0100", bus.ack); end
        bus.req = 4'b0000;
        tick;
        n = 0;
        while (bus.eng_abort !== 1'b1 && n < 300) begin tick; n++; end
        vectors++; if (n !== 100) begin miscompares++; $display("FAIL wdt_latency got %0d want 100", n); end
        vectors++; if (bus.cmd_done !== 4'b0100) begin miscompares++; $display("FAIL wdt_cmd_done got %b want 0100", bus.cmd_done); end
        vectors++; if (bus.err_timeout !== 1'b1) begin miscompares++; $display("FAIL wdt_err got %b want 1", bus.err_timeout); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL wdt_busy got %b want 0", bus.busy); end
        tick;
        vectors++; if (bus.eng_abort !== 1'b0) begin miscompares++; $display("FAIL wdt_abort_width got %b want 0", bus.eng_abort); end
        vectors++; if (bus.err_timeout !== 1'b1) begin miscompares++; $display("FAIL wdt_err_sticky got %b want 1", bus.err_timeout); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.err_timeout !== 1'b0) begin miscompares++; $display("FAIL wdt_err_rst got %b want 0", bus.err_timeout); end
        tick;
        rst = 1'b0;
        tick;
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_cmd();
        test_swapped_corners();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
`ifdef SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
